// File: rtl/pc_predict_unit_if.sv
// Fetch-side bus of the PC/branch-prediction unit: stall input, fetch PC and
// prediction outputs, branch-resolve inputs from later stages, and flush.
interface pc_predict_unit_if #(
    parameter int ADDR_W = 64
);
    logic              stall;
    logic [ADDR_W-1:0] pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              resolve_valid;
    logic [ADDR_W-1:0] resolve_pc;
    logic              resolve_uncond;
    logic              resolve_taken;
    logic [25:0]       resolve_imm26;
    logic [18:0]       resolve_imm19;
    logic              resolve_pred_taken;
    logic [ADDR_W-1:0] resolve_pred_target;
    logic              flush;

    // Pipeline side: drives stall and resolve information, consumes fetch PC.
    modport master (
        output stall, resolve_valid, resolve_pc, resolve_uncond, resolve_taken,
               resolve_imm26, resolve_imm19, resolve_pred_taken, resolve_pred_target,
        input  pc, pred_taken, pred_target, flush
    );

    // PC unit side.
    modport slave (
        input  stall, resolve_valid, resolve_pc, resolve_uncond, resolve_taken,
               resolve_imm26, resolve_imm19, resolve_pred_taken, resolve_pred_target,
        output pc, pred_taken, pred_target, flush
    );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC register with stall hold, a direct-mapped BTB with 2-bit
// saturating counters, and mispredict detection / redirect for branches
// resolved later in the pipe.
module pc_predict_unit #(
    parameter int                ADDR_W    = 64,
    parameter int                BTB_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input logic              clk,
    input logic              reset_n,
    pc_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;

    logic              btb_valid  [BTB_DEPTH];
    logic [1:0]        btb_ctr    [BTB_DEPTH];
    tag_t              btb_tag    [BTB_DEPTH];
    logic [ADDR_W-1:0] btb_target [BTB_DEPTH];

    // Fetch-side lookup fields.
    idx_t fetch_idx;
    tag_t fetch_tag;
    logic fetch_hit;
    logic pred_taken;

    // Resolve-side fields.
    idx_t              res_idx;
    tag_t              res_tag;
    logic              res_hit;
    logic              taken_act;
    logic [ADDR_W-1:0] imm_off;
    logic [ADDR_W-1:0] res_target;
    logic [ADDR_W-1:0] next_act;
    logic              mispredict;
    logic [1:0]        ctr_upd;

    assign fetch_idx = pc_q[IDX_W+1:2];
    assign fetch_tag = pc_q[ADDR_W-1:IDX_W+2];
    assign res_idx   = bus.resolve_pc[IDX_W+1:2];
    assign res_tag   = bus.resolve_pc[ADDR_W-1:IDX_W+2];

    // BTB lookup on the current fetch PC; reads the pre-update contents.
    always_comb begin
        fetch_hit       = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
        pred_taken      = fetch_hit && btb_ctr[fetch_idx][1];
        bus.pred_taken  = pred_taken;
        bus.pred_target = pred_taken ? btb_target[fetch_idx] : '0;
    end

    // Actual branch outcome, target arithmetic and mispredict detection.
    always_comb begin
        taken_act  = bus.resolve_uncond || bus.resolve_taken;
        imm_off    = bus.resolve_uncond
                   ? {{(ADDR_W-28){bus.resolve_imm26[25]}}, bus.resolve_imm26, 2'b00}
                   : {{(ADDR_W-21){bus.resolve_imm19[18]}}, bus.resolve_imm19, 2'b00};
        res_target = bus.resolve_pc + imm_off;
        next_act   = taken_act ? res_target : bus.resolve_pc + ADDR_W'(4);
        mispredict = bus.resolve_valid &&
                     ((bus.resolve_pred_taken != taken_act) ||
                      (taken_act && (bus.resolve_pred_target != res_target)));
        // Flush stays low while reset is held, whatever the resolve inputs say.
        bus.flush  = reset_n && mispredict;
    end

    // Next-PC selection: mispredict beats stall, stall beats prediction.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        pc_next = pc_q + ADDR_W'(4);
        if (mispredict)
            pc_next = next_act;
        else if (bus.stall)
            pc_next = pc_q;
        else if (pred_taken)
            pc_next = btb_target[fetch_idx];
    end

    // New counter value for the entry addressed by the resolving branch.
    always_comb begin
        res_hit = btb_valid[res_idx] && (btb_tag[res_idx] == res_tag);
        ctr_upd = btb_ctr[res_idx];
        if (taken_act) begin
            if (bus.resolve_uncond)
                ctr_upd = 2'b11;
            else if (!res_hit)
                ctr_upd = 2'b10;
            else if (btb_ctr[res_idx] != 2'b11)
                ctr_upd = btb_ctr[res_idx] + 2'd1;
        end else if (res_hit && (btb_ctr[res_idx] != 2'b00)) begin
            ctr_upd = btb_ctr[res_idx] - 2'd1;
        end
    end

    // PC register plus BTB valid bits and counters, all cleared on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
            pc_q <= RESET_PC;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_valid[i] <= 1'b0;
                btb_ctr[i]   <= 2'b01;
            end
        end else begin
            pc_q <= pc_next;
            if (bus.resolve_valid) begin
                if (taken_act)
                    btb_valid[res_idx] <= 1'b1;
                if (taken_act || res_hit)
                    btb_ctr[res_idx] <= ctr_upd;
            end
        end
    end

    // BTB tag/target storage, written on every taken resolve.
    always_ff @(posedge clk) begin
        // NOTE: tag/target RAM is not reset; the valid bits alone make stale contents harmless.
        if (bus.resolve_valid && taken_act) begin
            btb_tag[res_idx]    <= res_tag;
            btb_target[res_idx] <= res_target;
        end
    end

    assign bus.pc = pc_q;
endmodule

// File: tb/tb_pc_predict_unit.sv
// Self-checking bench for pc_predict_unit: directed scenarios followed by
// randomized traffic, checked through an expectation queue against an
// arithmetic model of the fetch PC and branch target buffer.
module tb_pc_predict_unit;
    localparam int D = 16;

    typedef struct {
        logic [63:0] pc;
        logic        pt;
        logic [63:0] ptg;
        logic        fl;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Model state.
    logic [63:0] m_pc;
    bit          m_valid [D];
    logic [63:0] m_tag   [D];
    logic [63:0] m_tgt   [D];
    int          m_ctr   [D];

    pc_predict_unit_if #(.ADDR_W(64)) bus ();

    pc_predict_unit #(.ADDR_W(64), .BTB_DEPTH(D), .RESET_PC(64'h0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 64'h0;
        for (int i = 0; i < D; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        return int'((a / 4) % D);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] a);
        return a / (4 * D);
    endfunction

    function automatic void lookup(input logic [63:0] a, output bit t, output logic [63:0] tgt);
        int i = idx_of(a);
        t   = m_valid[i] && (m_tag[i] == tag_of(a)) && (m_ctr[i] >= 2);
        tgt = t ? m_tgt[i] : 64'h0;
    endfunction

    // One cycle of stimulus; called mid-cycle, returns at the next posedge + 1.
    task automatic drive(input bit st, input bit rv, input logic [63:0] rpc, input bit unc,
                         input bit tk, input logic [25:0] i26, input logic [18:0] i19,
                         input bit rpt, input logic [63:0] rptg);
        exp_t        e;
        bit          ta, mis, pt, hit;
        longint      off;
        logic [63:0] tgt, ptg;
        int          i;
        bus.stall = st;
        bus.resolve_valid = rv;
        bus.resolve_pc = rpc;
        bus.resolve_uncond = unc;
        bus.resolve_taken = tk;
        bus.resolve_imm26 = i26;
        bus.resolve_imm19 = i19;
        bus.resolve_pred_taken = rpt;
        bus.resolve_pred_target = rptg;

        ta  = unc || tk;
        off = unc ? longint'($signed(i26)) : longint'($signed(i19));
        tgt = rpc + 64'(off * 4);
        mis = rv && ((rpt != ta) || (ta && rptg != tgt));
        lookup(m_pc, pt, ptg);
        e.pc = m_pc; e.pt = pt; e.ptg = ptg; e.fl = mis;
        sb_q.push_back(e);

        if (mis)      m_pc = ta ? tgt : rpc + 64'd4;
        else if (st)  m_pc = m_pc;
        else if (pt)  m_pc = ptg;
        else          m_pc = m_pc + 64'd4;

        if (rv) begin
            i   = idx_of(rpc);
            hit = m_valid[i] && (m_tag[i] == tag_of(rpc));
            if (ta) begin
                m_ctr[i]   = unc ? 3 : (hit ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1) : 2);
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(rpc);
                m_tgt[i]   = tgt;
            end else if (hit) begin
                m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 64'h0, 0, 0, 26'h0, 19'h0, 0, 64'h0);
    endtask

    // Forces a mispredict whose fall-through lands on a.
    task automatic redirect_to(input logic [63:0] a);
        drive(0, 1, a - 64'd4, 0, 0, 26'h0, 19'h0, 1, 64'h0);
    endtask

    // Monitor: compares every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc", bus.pc, e.pc);
                check("pred_taken", 64'(bus.pred_taken), 64'(e.pt));
                check("pred_target", bus.pred_target, e.ptg);
                check("flush", 64'(bus.flush), 64'(e.fl));
            end
        end
    end

    initial begin
        bus.stall = 0;
        bus.resolve_valid = 1;
        bus.resolve_pc = 64'h100;
        bus.resolve_uncond = 0;
        bus.resolve_taken = 0;
        bus.resolve_imm26 = '0;
        bus.resolve_imm19 = '0;
        bus.resolve_pred_taken = 1;
        bus.resolve_pred_target = '0;
        model_reset();
        #1 reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", bus.pc, 64'h0);
        check("rst_flush", 64'(bus.flush), 64'h0);
        check("rst_pred", 64'(bus.pred_taken), 64'h0);

        // Release and count up: 0, 4, 8, ... 0x1C.
        @(posedge clk);
        #2 reset_n = 1;
        repeat (8) idle();
        #1;
        check("pre_rst_pc", bus.pc, 64'h20);
        reset_n = 0;
        bus.resolve_valid = 1;
        bus.resolve_pred_taken = 1;
        #1;
        check("async_rst_pc", bus.pc, 64'h0);
        check("async_rst_flush", 64'(bus.flush), 64'h0);
        @(posedge clk);
        #2 reset_n = 1;
        model_reset();

        // Cold conditional branch at 0x10, imm19=2 -> target 0x18.
        drive(0, 1, 64'h10, 0, 1, 26'h0, 19'd2, 0, 64'h0);
        idle();
        // Warm hit at 0x10; resolve it correctly in the same cycle.
        redirect_to(64'h10);
        drive(0, 1, 64'h10, 0, 1, 26'h0, 19'd2, 1, 64'h18);
        // Train down twice, then fetch 0x10 again.
        drive(0, 1, 64'h10, 0, 0, 26'h0, 19'd2, 1, 64'h18);
        drive(0, 1, 64'h10, 0, 0, 26'h0, 19'd2, 0, 64'h0);
        redirect_to(64'h10);
        idle();
        idle();
        // Stall at 0x40, then stall together with a mispredict to 0x80.
        redirect_to(64'h40);
        repeat (3) drive(1, 0, 64'h0, 0, 0, 26'h0, 19'h0, 0, 64'h0);
        drive(1, 1, 64'h70, 0, 1, 26'h0, 19'd4, 0, 64'h0);
        redirect_to(64'h70);
        idle();
        // Unconditional branch at 0x40 with offset -1 word -> 0x3C.
        drive(0, 1, 64'h40, 1, 0, 26'h3FFFFFF, 19'h0, 0, 64'h0);
        redirect_to(64'h40);
        repeat (3) idle();
        // Retrain 0x10 up, then alias through 0x50 (same index, other tag).
        drive(0, 1, 64'h10, 0, 1, 26'h0, 19'd2, 0, 64'h18);
        drive(0, 1, 64'h10, 0, 1, 26'h0, 19'd2, 1, 64'h18);
        redirect_to(64'h10);
        idle();
        redirect_to(64'h50);
        idle();
        // Wrap-around of pc + 4.
        redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
        idle();
        idle();

        // Randomized traffic around a small hot set of branch addresses.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] rpc, tgt, ptg;
            bit          st, rv, unc, tk, rpt, pt;
            int          o;
            logic [25:0] i26;
            logic [18:0] i19;
            rpc = 64'($urandom_range(31)) * 4;
            if ($urandom_range(3) == 0) rpc = rpc | 64'h200;
            st  = ($urandom_range(4) == 0);
            rv  = ($urandom_range(1) == 1);
            unc = ($urandom_range(3) == 0);
            tk  = ($urandom_range(1) == 1);
            o   = int'($urandom_range(16)) - 8;
            i19 = 19'(o);
            i26 = ($urandom_range(7) == 0) ? 26'h3FFFFFF : 26'(o);
            lookup(rpc, pt, ptg);
            if ($urandom_range(1) == 1) begin
                rpt = pt;
                tgt = ptg;
            end else begin
                rpt = ($urandom_range(1) == 1);
                tgt = rpc + 64'($urandom_range(3)) * 4;
            end
            if ($urandom_range(15) == 0) redirect_to(rpc);
            drive(st, rv, rpc, unc, tk, i26, i19, rpt, tgt);
        end

        bus.resolve_valid = 0;
        @(posedge clk);
        #1;
        check("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Fetch-stage program-counter unit for the 5-stage pipeline; successor to the combinational next-PC logic.
- Holds the PC register and adds stall hold.
- Predicts branches through a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Checks branches resolved later in the pipe, updates the BTB, and issues a flush plus redirect on mispredict.

Parameters:
- ADDR_W, 64, PC/address width in bits.
- BTB_DEPTH, 16, number of BTB entries; power of 2, at least 2. IDX_W = log2(BTB_DEPTH).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous reset, active-low
- stall  in  1  hold the PC this cycle
- pc  out  ADDR_W  current fetch PC (registered)
- pred_taken  out  1  BTB predicts the branch at pc is taken
- pred_target  out  ADDR_W  predicted target; 0 when pred_taken=0
- resolve_valid  in  1  a branch resolves this cycle
- resolve_pc  in  ADDR_W  address of the resolving branch
- resolve_uncond  in  1  1 = B (Imm26), 0 = conditional (Imm19)
- resolve_taken  in  1  actual outcome; ignored and treated as 1 when resolve_uncond=1
- resolve_imm26  in  26  signed word offset
- resolve_imm19  in  19  signed word offset
- resolve_pred_taken  in  1  prediction made at fetch for this branch
- resolve_pred_target  in  ADDR_W  target predicted at fetch
- flush  out  1  mispredict; younger stages must squash

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - pc = RESET_PC.
  - All BTB valid bits = 0; all counters = 2'b01.
  - flush and pred_taken are 0 while reset_n = 0.
- Address fields:
  - index = pc[IDX_W+1:2].
  - tag = pc[ADDR_W-1:IDX_W+2].
  - pc[1:0] is never stored.
- Lookup (combinational on pc):
  - hit = valid[index] and tag matches.
  - pred_taken = hit and counter[1].
  - pred_target = stored target when pred_taken, else 0.
- Target arithmetic:
  - target = resolve_pc + (sign-extend(imm) << 2).
  - imm is Imm26 when resolve_uncond=1, else Imm19.
  - All adds, including pc+4, are modulo 2^ADDR_W; wrap-around is silent.
- Actual outcome:
  - taken_act = resolve_uncond or resolve_taken.
  - next_act = taken_act ? target : resolve_pc + 4.
- Mispredict (combinational, valid only with resolve_valid=1):
  - resolve_pred_taken != taken_act, or
  - taken_act and resolve_pred_target != target.
  - flush = mispredict, asserted in the same cycle.
- Next PC priority, latched at the rising edge:
  1. mispredict -> next_act; overrides stall.
  2. stall -> pc held.
  3. pred_taken -> pred_target.
  4. otherwise -> pc + 4.
- BTB update at the edge when resolve_valid=1; stall does not block it:
  - taken_act with tag hit: target rewritten; counter saturating +1, or set to 2'b11 if uncond.
  - taken_act with miss: allocate/overwrite the entry (valid=1, tag, target); counter = 2'b10, or 2'b11 if uncond.
  - Not taken with tag hit: counter saturating -1; entry stays valid.
  - Not taken with miss: no change; no allocation.
- Write/read ordering:
  - A same-cycle lookup at the index being written sees the old contents.
  - The new contents are visible from the next cycle.
- Latency: one cycle from redirect decision to the new pc. No internal pipelining of the resolve path.

Test Plan:
- Reset sequence:
  - Hold reset_n=0 -> pc=0, flush=0, pred_taken=0.
  - Release with stall=0, no resolves -> pc 4, 8, 12 on successive edges.
  - Assert reset_n=0 mid-run with pc=0x20 -> pc=0 immediately, without a clock edge.
- Cold conditional branch:
  - Resolve pc=0x10, taken=1, imm19=2, pred_taken=0 -> flush=1 that cycle, next pc=0x18.
  - Entry idx 4 becomes valid with target 0x18, counter 2'b10.
- Warm hit:
  - pc=0x10 -> pred_taken=1, pred_target=0x18, next pc=0x18.
  - Resolve taken with pred_target 0x18 -> flush=0, counter 2'b11.
- Train down:
  - Resolve 0x10 not-taken with pred_taken=1 -> flush=1, pc<=0x14, counter 2'b10.
  - Resolve again not-taken -> counter 2'b01.
  - Fetch 0x10 -> pred_taken=0, next pc=0x14.
- Stall interaction:
  - stall=1 for 3 cycles at pc=0x40 -> pc stays 0x40.
  - stall=1 together with a mispredict resolve (next_act=0x80) -> pc=0x80; BTB still updated.
- Unconditional and aliasing:
  - Resolve B at 0x40 with imm26=26'h3FFFFFF -> target 0x3C; counter 2'b11.
  - Fetch 0x50 after 0x10 is trained (same idx 4, different tag) -> pred_taken=0.
  - pc=2^64-4 with no branch -> wraps to 0.
